// File: rtl/id_ex_stage_reg_pkg.sv
// id_ex_stage_reg_pkg: memory access encodings shared with the bypass mux and MM, plus hazard helpers
package id_ex_stage_reg_pkg;

  typedef enum logic [1:0] {
    MEM_ACCESS_TYPE_NONE = 2'b00,
    MEM_ACCESS_TYPE_R2R  = 2'b01,
    MEM_ACCESS_TYPE_M2R  = 2'b10,
    MEM_ACCESS_TYPE_R2M  = 2'b11
  } mem_access_type_e;

  function automatic logic src_hit(input logic used, input logic [4:0] src, input logic [4:0] dest);
    return used && (src == dest);
  endfunction

endpackage

// File: rtl/id_ex_stage_reg_load_use_detect.sv
// id_ex_stage_reg_load_use_detect: flags an ID source that depends on a load still sitting in EX
module id_ex_stage_reg_load_use_detect
  import id_ex_stage_reg_pkg::*;
(
  input  logic       id_valid,
  input  logic       ex_valid,
  input  logic [4:0] id_rs_addr,
  input  logic [4:0] id_rt_addr,
  input  logic       id_rs_used,
  input  logic       id_rt_used,
  input  logic [4:0] ex_dest_addr,
  input  logic [1:0] ex_access_type,
  output logic       load_use_stall
);

  assign load_use_stall = id_valid && ex_valid &&
                          (ex_access_type == MEM_ACCESS_TYPE_M2R) && (ex_dest_addr != 5'd0) &&
                          (src_hit(id_rs_used, id_rs_addr, ex_dest_addr) ||
                           src_hit(id_rt_used, id_rt_addr, ex_dest_addr));

endmodule

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with load-use bubble insertion, EX hold and flush
module id_ex_stage_reg
  import id_ex_stage_reg_pkg::*;
#(
  parameter int ALU_OP_W = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                ex_hold,
  input  logic                id_valid,
  input  logic [31:0]         id_pc,
  input  logic [31:0]         id_op_a,
  input  logic [31:0]         id_op_b,
  input  logic [4:0]          id_rs_addr,
  input  logic [4:0]          id_rt_addr,
  input  logic                id_rs_used,
  input  logic                id_rt_used,
  input  logic [4:0]          id_dest_addr,
  input  logic [1:0]          id_access_type,
  input  logic [ALU_OP_W-1:0] id_alu_op,
  input  logic                id_in_delay_slot,
  output logic                ex_valid,
  output logic [31:0]         ex_pc,
  output logic [31:0]         ex_op_a,
  output logic [31:0]         ex_op_b,
  output logic [4:0]          ex_dest_addr,
  output logic [1:0]          ex_access_type,
  output logic [ALU_OP_W-1:0] ex_alu_op,
  output logic                ex_in_delay_slot,
  output logic                id_stall,
  output logic                load_use_stall
);

  logic                valid_d, valid_q;
  logic [31:0]         pc_d, pc_q, op_a_d, op_a_q, op_b_d, op_b_q;
  logic [4:0]          dest_d, dest_q;
  logic [1:0]          access_d, access_q;
  logic [ALU_OP_W-1:0] alu_op_d, alu_op_q;
  logic                ds_d, ds_q;
  logic                keep, take;

  id_ex_stage_reg_load_use_detect u_detect (
    .id_valid       (id_valid),
    .ex_valid       (valid_q),
    .id_rs_addr     (id_rs_addr),
    .id_rt_addr     (id_rt_addr),
    .id_rs_used     (id_rs_used),
    .id_rt_used     (id_rt_used),
    .ex_dest_addr   (dest_q),
    .ex_access_type (access_q),
    .load_use_stall (load_use_stall)
  );

  assign id_stall = !flush && (ex_hold || load_use_stall);

  // Anything neither kept nor taken becomes a bubble, including invalid ID slots
  always_comb begin
    keep     = !flush && ex_hold;
    take     = !flush && !ex_hold && !load_use_stall && id_valid;
    valid_d  = keep ? valid_q  : take;
    pc_d     = keep ? pc_q     : take ? id_pc            : 32'd0;
    op_a_d   = keep ? op_a_q   : take ? id_op_a          : 32'd0;
    op_b_d   = keep ? op_b_q   : take ? id_op_b          : 32'd0;
    dest_d   = keep ? dest_q   : take ? id_dest_addr     : 5'd0;
    access_d = keep ? access_q : take ? id_access_type   : MEM_ACCESS_TYPE_NONE;
    alu_op_d = keep ? alu_op_q : take ? id_alu_op        : '0;
    ds_d     = keep ? ds_q     : take && id_in_delay_slot;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      pc_q     <= 32'd0;
      op_a_q   <= 32'd0;
      op_b_q   <= 32'd0;
      dest_q   <= 5'd0;
      access_q <= MEM_ACCESS_TYPE_NONE;
      alu_op_q <= '0;
      ds_q     <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      dest_q   <= dest_d;
      access_q <= access_d;
      alu_op_q <= alu_op_d;
      ds_q     <= ds_d;
    end
  end

  assign ex_valid         = valid_q;
  assign ex_pc            = pc_q;
  assign ex_op_a          = op_a_q;
  assign ex_op_b          = op_b_q;
  assign ex_dest_addr     = dest_q;
  assign ex_access_type   = access_q;
  assign ex_alu_op        = alu_op_q;
  assign ex_in_delay_slot = ds_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb_id_ex_stage_reg: directed vectors with a scoreboard queue checked by a negedge monitor
module tb_id_ex_stage_reg;

  typedef struct packed {
    logic        rst_n, flush, hold, valid;
    logic [31:0] pc, a, b;
    logic [4:0]  rs, rt;
    logic        rsu, rtu;
    logic [4:0]  dest;
    logic [1:0]  acc;
    logic [5:0]  alu;
    logic        ds;
  } stim_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, a, b;
    logic [4:0]  dest;
    logic [1:0]  acc;
    logic [5:0]  alu;
    logic        ds, stall, lus;
  } exp_t;

  localparam exp_t BUB = '0;

  logic        clk = 1'b0;
  logic        rst_n, flush, ex_hold, id_valid;
  logic [31:0] id_pc, id_op_a, id_op_b;
  logic [4:0]  id_rs_addr, id_rt_addr, id_dest_addr;
  logic        id_rs_used, id_rt_used, id_in_delay_slot;
  logic [1:0]  id_access_type;
  logic [5:0]  id_alu_op;
  logic        ex_valid, ex_in_delay_slot, id_stall, load_use_stall;
  logic [31:0] ex_pc, ex_op_a, ex_op_b;
  logic [4:0]  ex_dest_addr;
  logic [1:0]  ex_access_type;
  logic [5:0]  ex_alu_op;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  id_ex_stage_reg #(.ALU_OP_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .ex_hold(ex_hold), .id_valid(id_valid),
    .id_pc(id_pc), .id_op_a(id_op_a), .id_op_b(id_op_b),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_dest_addr(id_dest_addr), .id_access_type(id_access_type),
    .id_alu_op(id_alu_op), .id_in_delay_slot(id_in_delay_slot),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
    .ex_dest_addr(ex_dest_addr), .ex_access_type(ex_access_type),
    .ex_alu_op(ex_alu_op), .ex_in_delay_slot(ex_in_delay_slot),
    .id_stall(id_stall), .load_use_stall(load_use_stall)
  );

  always #5 clk = ~clk;

  task automatic apply(input stim_t s);
    rst_n = s.rst_n; flush = s.flush; ex_hold = s.hold; id_valid = s.valid;
    id_pc = s.pc; id_op_a = s.a; id_op_b = s.b;
    id_rs_addr = s.rs; id_rt_addr = s.rt; id_rs_used = s.rsu; id_rt_used = s.rtu;
    id_dest_addr = s.dest; id_access_type = s.acc; id_alu_op = s.alu; id_in_delay_slot = s.ds;
  endtask

  task automatic step(input stim_t s, input exp_t e);
    @(posedge clk);
    #1;
    apply(s);
    sb.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      check("ex_valid",         {31'd0, ex_valid},         {31'd0, e.valid});
      check("ex_pc",            ex_pc,                     e.pc);
      check("ex_op_a",          ex_op_a,                   e.a);
      check("ex_op_b",          ex_op_b,                   e.b);
      check("ex_dest_addr",     {27'd0, ex_dest_addr},     {27'd0, e.dest});
      check("ex_access_type",   {30'd0, ex_access_type},   {30'd0, e.acc});
      check("ex_alu_op",        {26'd0, ex_alu_op},        {26'd0, e.alu});
      check("ex_in_delay_slot", {31'd0, ex_in_delay_slot}, {31'd0, e.ds});
      check("id_stall",         {31'd0, id_stall},         {31'd0, e.stall});
      check("load_use_stall",   {31'd0, load_use_stall},   {31'd0, e.lus});
    end
  end

  // stim: rst_n,flush,hold,valid,pc,a,b,rs,rt,rsu,rtu,dest,acc,alu,ds
  // exp : valid,pc,a,b,dest,acc,alu,ds,stall,lus  (EX contents visible during that cycle)
  initial begin
    apply('{1'b0,1'b0,1'b0,1'b1,32'hdeadbeef,32'h1,32'h2,5'd9,5'd9,1'b1,1'b1,5'd3,2'b10,6'h3f,1'b1});
    // reset held for two edges
    step('{1'b0,1'b0,1'b0,1'b1,32'h00401000,32'h1,32'h2,5'd9,5'd9,1'b1,1'b1,5'd3,2'b10,6'h3f,1'b1}, BUB);
    // plain advance
    step('{1'b1,1'b0,1'b0,1'b1,32'h00400010,32'd5,32'd7,5'd1,5'd2,1'b1,1'b1,5'd8,2'b01,6'h0a,1'b0}, BUB);
    step('{1'b1,1'b0,1'b0,1'b1,32'h00400014,32'h100,32'd4,5'd8,5'd0,1'b1,1'b0,5'd9,2'b10,6'h20,1'b0},
         '{1'b1,32'h00400010,32'd5,32'd7,5'd8,2'b01,6'h0a,1'b0,1'b0,1'b0});
    // load-use on rs: stall, bubble, then the consumer enters
    step('{1'b1,1'b0,1'b0,1'b1,32'h00400018,32'h11,32'h22,5'd9,5'd3,1'b1,1'b1,5'd10,2'b01,6'h01,1'b1},
         '{1'b1,32'h00400014,32'h100,32'd4,5'd9,2'b10,6'h20,1'b0,1'b1,1'b1});
    step('{1'b1,1'b0,1'b0,1'b1,32'h00400018,32'h11,32'h22,5'd9,5'd3,1'b1,1'b1,5'd10,2'b01,6'h01,1'b1}, BUB);
    step('{1'b1,1'b0,1'b0,1'b1,32'h0040001c,32'd1,32'd2,5'd9,5'd9,1'b1,1'b1,5'd0,2'b10,6'h20,1'b0},
         '{1'b1,32'h00400018,32'h11,32'h22,5'd10,2'b01,6'h01,1'b1,1'b0,1'b0});
    // load into r0 never stalls
    step('{1'b1,1'b0,1'b0,1'b1,32'h00400020,32'd3,32'd4,5'd0,5'd0,1'b1,1'b1,5'd11,2'b01,6'h02,1'b0},
         '{1'b1,32'h0040001c,32'd1,32'd2,5'd0,2'b10,6'h20,1'b0,1'b0,1'b0});
    step('{1'b1,1'b0,1'b0,1'b1,32'h00400024,32'd5,32'd6,5'd1,5'd2,1'b1,1'b1,5'd9,2'b10,6'h21,1'b0},
         '{1'b1,32'h00400020,32'd3,32'd4,5'd11,2'b01,6'h02,1'b0,1'b0,1'b0});
    // rt matches but is unused
    step('{1'b1,1'b0,1'b0,1'b1,32'h00400028,32'd7,32'd8,5'd4,5'd9,1'b1,1'b0,5'd12,2'b01,6'h03,1'b0},
         '{1'b1,32'h00400024,32'd5,32'd6,5'd9,2'b10,6'h21,1'b0,1'b0,1'b0});
    // R2R producer of r9 followed by a reader is not a load-use
    step('{1'b1,1'b0,1'b0,1'b1,32'h0040002c,32'd9,32'd10,5'd12,5'd0,1'b1,1'b0,5'd9,2'b01,6'h04,1'b0},
         '{1'b1,32'h00400028,32'd7,32'd8,5'd12,2'b01,6'h03,1'b0,1'b0,1'b0});
    step('{1'b1,1'b0,1'b0,1'b1,32'h00400030,32'd11,32'd12,5'd9,5'd9,1'b1,1'b1,5'd13,2'b01,6'h05,1'b0},
         '{1'b1,32'h0040002c,32'd9,32'd10,5'd9,2'b01,6'h04,1'b0,1'b0,1'b0});
    // hold for three cycles over a hazard, then exactly one bubble
    step('{1'b1,1'b0,1'b0,1'b1,32'h00400034,32'd13,32'd14,5'd1,5'd0,1'b1,1'b0,5'd9,2'b10,6'h22,1'b0},
         '{1'b1,32'h00400030,32'd11,32'd12,5'd13,2'b01,6'h05,1'b0,1'b0,1'b0});
    for (int i = 0; i < 4; i++)
      step('{1'b1,1'b0,(i < 3),1'b1,32'h00400038,32'd15,32'd16,5'd9,5'd0,1'b1,1'b0,5'd14,2'b01,6'h06,1'b0},
           '{1'b1,32'h00400034,32'd13,32'd14,5'd9,2'b10,6'h22,1'b0,1'b1,1'b1});
    step('{1'b1,1'b0,1'b0,1'b1,32'h00400038,32'd15,32'd16,5'd9,5'd0,1'b1,1'b0,5'd14,2'b01,6'h06,1'b0}, BUB);
    // flush during hold: bubble wins, id_stall forced low
    step('{1'b1,1'b0,1'b0,1'b1,32'h0040003c,32'd17,32'd18,5'd1,5'd0,1'b1,1'b0,5'd9,2'b10,6'h23,1'b0},
         '{1'b1,32'h00400038,32'd15,32'd16,5'd14,2'b01,6'h06,1'b0,1'b0,1'b0});
    step('{1'b1,1'b0,1'b1,1'b1,32'h00400040,32'd19,32'd20,5'd9,5'd0,1'b1,1'b0,5'd15,2'b01,6'h07,1'b0},
         '{1'b1,32'h0040003c,32'd17,32'd18,5'd9,2'b10,6'h23,1'b0,1'b1,1'b1});
    step('{1'b1,1'b1,1'b1,1'b1,32'h00400040,32'd19,32'd20,5'd9,5'd0,1'b1,1'b0,5'd15,2'b01,6'h07,1'b0},
         '{1'b1,32'h0040003c,32'd17,32'd18,5'd9,2'b10,6'h23,1'b0,1'b0,1'b1});
    step('{1'b1,1'b0,1'b0,1'b1,32'h00400040,32'd19,32'd20,5'd9,5'd0,1'b1,1'b0,5'd15,2'b01,6'h07,1'b0}, BUB);
    // invalid ID slot is stored as a bubble
    step('{1'b1,1'b0,1'b0,1'b0,32'h00400044,32'd1,32'd1,5'd0,5'd0,1'b0,1'b0,5'd16,2'b01,6'h08,1'b1},
         '{1'b1,32'h00400040,32'd19,32'd20,5'd15,2'b01,6'h07,1'b0,1'b0,1'b0});
    // reset asserted during a load-use stall
    step('{1'b1,1'b0,1'b0,1'b1,32'h00400048,32'd21,32'd22,5'd1,5'd0,1'b1,1'b0,5'd9,2'b10,6'h24,1'b0}, BUB);
    step('{1'b0,1'b0,1'b0,1'b1,32'h0040004c,32'd23,32'd24,5'd9,5'd0,1'b1,1'b0,5'd17,2'b01,6'h08,1'b0},
         '{1'b1,32'h00400048,32'd21,32'd22,5'd9,2'b10,6'h24,1'b0,1'b1,1'b1});
    step('{1'b1,1'b0,1'b0,1'b1,32'h0040004c,32'd23,32'd24,5'd9,5'd0,1'b1,1'b0,5'd17,2'b01,6'h08,1'b0}, BUB);
    // back-to-back loads into r9: each consumer stalls once
    step('{1'b1,1'b0,1'b0,1'b1,32'h00400050,32'd25,32'd26,5'd1,5'd0,1'b1,1'b0,5'd9,2'b10,6'h25,1'b0},
         '{1'b1,32'h0040004c,32'd23,32'd24,5'd17,2'b01,6'h08,1'b0,1'b0,1'b0});
    step('{1'b1,1'b0,1'b0,1'b1,32'h00400054,32'd27,32'd28,5'd9,5'd0,1'b1,1'b0,5'd9,2'b10,6'h26,1'b0},
         '{1'b1,32'h00400050,32'd25,32'd26,5'd9,2'b10,6'h25,1'b0,1'b1,1'b1});
    step('{1'b1,1'b0,1'b0,1'b1,32'h00400054,32'd27,32'd28,5'd9,5'd0,1'b1,1'b0,5'd9,2'b10,6'h26,1'b0}, BUB);
    step('{1'b1,1'b0,1'b0,1'b1,32'h00400058,32'd29,32'd30,5'd2,5'd9,1'b1,1'b1,5'd18,2'b01,6'h09,1'b0},
         '{1'b1,32'h00400054,32'd27,32'd28,5'd9,2'b10,6'h26,1'b0,1'b1,1'b1});
    step('{1'b1,1'b0,1'b0,1'b1,32'h00400058,32'd29,32'd30,5'd2,5'd9,1'b1,1'b1,5'd18,2'b01,6'h09,1'b0}, BUB);
    step('0, '{1'b1,32'h00400058,32'd29,32'd30,5'd18,2'b01,6'h09,1'b0,1'b0,1'b0});
    step('{1'b1,1'b0,1'b0,1'b0,32'd0,32'd0,32'd0,5'd0,5'd0,1'b0,1'b0,5'd0,2'b00,6'h00,1'b0}, BUB);
    for (int i = 0; i < 5 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage_reg.md
# id_ex_stage_reg

ID/EX pipeline register for the five-stage CPU. It latches the operands produced by the ID-stage bypass muxes plus decoded control, and presents them to EX. Its registered `ex_dest_addr`/`ex_access_type` are the EX-side bypass source fed back to ID. It also detects load-use hazards, stalls IF/ID and inserts a bubble, and honours EX-side holds and pipeline flushes.

## Interface
Parameters:
- `ALU_OP_W`, default 6: width of the decoded ALU operation field.

Ports:
- `clk`  in  1  the single clock for the block.
- `rst_n`  in  1  reset; synchronous, active-low.
- `flush`  in  1  exception/eret flush; kills the instruction entering EX.
- `ex_hold`  in  1  EX busy (multi-cycle mult/div); freeze this register.
- `id_valid`  in  1  ID holds a real instruction.
- `id_pc`  in  32  PC of the ID instruction.
- `id_op_a`, `id_op_b`  in  32 each  operands from the bypass muxes.
- `id_rs_addr`, `id_rt_addr`  in  5 each  source register numbers.
- `id_rs_used`, `id_rt_used`  in  1 each  the operand is actually read.
- `id_dest_addr`  in  5  destination register.
- `id_access_type`  in  2  `MEM_ACCESS_TYPE_*`.
- `id_alu_op`  in  ALU_OP_W  decoded operation.
- `id_in_delay_slot`  in  1  the instruction is in a branch delay slot.
- `ex_valid`, `ex_pc`, `ex_op_a`, `ex_op_b`, `ex_dest_addr`, `ex_access_type`, `ex_alu_op`, `ex_in_delay_slot`  out  registered copies of the matching `id_*` fields.
- `id_stall`  out  1  combinational; freeze PC and IF/ID.
- `load_use_stall`  out  1  combinational; a load-use hazard is detected (for perf counters).

## Operation
- Load-use hazard: `load_use_stall` = `id_valid & ex_valid & (ex_access_type==MEM_ACCESS_TYPE_M2R) & (ex_dest_addr!=0) & ((id_rs_used & id_rs_addr==ex_dest_addr) | (id_rt_used & id_rt_addr==ex_dest_addr))`.
- `id_stall` = `ex_hold | load_use_stall`. The value is forced to 0 while `flush` is high.
- Per-edge action, priority highest first:
  1. `!rst_n`: clear.
  2. `flush`: load a bubble.
  3. `ex_hold`: keep all `ex_*` unchanged.
  4. `load_use_stall`: load a bubble.
  5. Otherwise: load the `id_*` fields.
- Bubble and clear are identical: `ex_valid`=0, `ex_access_type`=`MEM_ACCESS_TYPE_NONE`, `ex_dest_addr`=0, and every other output 0.
- An `id_*` load with `id_valid`=0 is also stored as a bubble. Invalid instructions therefore never advertise a destination to the bypass muxes.
- One bubble suffices for a load-use hazard. Next cycle the load is in MM, and the ID bypass selects `val_from_mm` for M2R.
- No internal state beyond the registers. The hazard result is recomputed every cycle.

## Timing
- Reset: synchronous on the `clk` posedge with `rst_n`=0. All registered outputs go to 0, and `ex_access_type` goes to `MEM_ACCESS_TYPE_NONE`.
- Latency: ID to EX outputs is one cycle.
- `id_stall` and `load_use_stall` are valid in the same cycle as their inputs, with no registered delay.
- `ex_hold` and `load_use_stall` both high: hold wins. No bubble is inserted while held. The hazard is re-evaluated after the hold drops.
- `flush` together with `ex_hold`: flush wins, so the bubble is loaded regardless.
- Reset asserted mid-stall: registers clear on that edge. The hazard then disappears because `ex_valid`=0.
- `ex_dest_addr`=0 load: never stalls.
- Back-to-back loads into the same register: each consumer stalls exactly one cycle.

## Structure
- The following encodings live in the shared `defs.v` and are used by the bypass mux, this block and MM:
  - `MEM_ACCESS_TYPE_NONE`=2'b00
  - `MEM_ACCESS_TYPE_R2R`=2'b01
  - `MEM_ACCESS_TYPE_M2R`=2'b10
  - `MEM_ACCESS_TYPE_R2M`=2'b11
- One natural sub-module is `load_use_detect`, purely combinational. It takes the ID source addresses and used flags plus the EX destination and access type, and outputs `load_use_stall`. The register bank stays in the top module.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with arbitrary `id_*` → all `ex_*`=0, `ex_access_type`=NONE, `id_stall`=0.
- Plain advance: `id_pc`=0x00400010, `id_op_a`=5, `id_dest_addr`=8, access R2R, valid → the next cycle shows `ex_pc`=0x00400010, `ex_op_a`=5, `ex_dest_addr`=8, `ex_valid`=1.
- Load-use: EX holds an M2R with dest 9; ID has `id_rs_addr`=9 and `id_rs_used`=1 →
  - `load_use_stall`=`id_stall`=1 in the same cycle.
  - Next cycle EX is a bubble with `ex_dest_addr`=0.
  - The same ID instruction enters EX one cycle later.
- Non-hazards, each giving `id_stall`=0:
  - EX M2R with dest 9 and ID `id_rt_addr`=9 but `id_rt_used`=0.
  - EX M2R with dest 0.
  - EX R2R with dest 9 and a reader of register 9.
- Hold and flush:
  - `ex_hold`=1 for 3 cycles while a hazard is present → `ex_*` stay constant and `id_stall`=1 throughout.
  - After release there is exactly one bubble cycle.
  - `flush`=1 during the hold → bubble next cycle and `id_stall`=0.
